aes_vector_loader: RTL and testbench
====================================

# aes_vector_loader

Upstream feeder for `aescipher`. Fetches 128-bit plaintext/key pairs from a synchronous vector memory and serializes each into the cipher's byte-wide `din`/`cmd` port. Issues the start command, then waits for `ok` before moving to the next vector. Sits between the vector ROM and `aescipher`. Provides the cipher's stimulus in self-running builds, with a done/error status for the bench.

## Interface
- `VEC_COUNT`, 20: number of plaintext/key pairs to process.
- `ADDR_W`, 8: vector memory address width; must satisfy 2*VEC_COUNT <= 2^ADDR_W.
- `OK_TIMEOUT`, 4096: maximum cycles to wait for `ok` after the start command.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_`  in  1  asynchronous, active-low reset.
- `address`  out  ADDR_W  vector memory read address, registered.
- `rdata`  in  128  memory read data, valid one cycle after `address` changes.
- `din`  out  8  byte to cipher, registered.
- `cmd`  out  2  cipher command: ID=00, ST=01, SK=10, SP=11; registered.
- `ready`  in  1  cipher idle/ready to accept a load.
- `ok`  in  1  cipher result-valid pulse.
- `vec_idx`  out  ADDR_W-1  index of the current vector.
- `done`  out  1  all vectors finished or aborted; sticky until reset.
- `err`  out  1  `ok` timeout occurred; sticky until reset.

## Operation
- Memory layout: word 2n holds the plaintext of vector n; word 2n+1 holds its key.
- Serialization order is LSB byte first: byte 0 = bits [7:0], byte 15 = bits [127:120].
- States:
  - IDLE: `cmd`=ID. Go to RD_PT when `ready`=1 and `done`=0.
  - RD_PT: `address`=2n for 2 cycles, then latch `rdata` into the shift register.
  - SEND_PT: 16 cycles with `cmd`=SP. `din`=sreg[7:0], then shift right 8.
  - GAP_PT: 1 cycle with `cmd`=ID.
  - RD_KEY and SEND_KEY: same as RD_PT/SEND_PT, with `address`=2n+1 and `cmd`=SK.
  - GAP_KEY: 1 cycle with `cmd`=ID.
  - START: 1 cycle with `cmd`=ST.
  - WAIT_OK: `cmd`=ID and the timeout counter runs.
    - `ok`=1: if n==VEC_COUNT-1, go to FIN; else increment n and go to IDLE.
    - Counter reaches OK_TIMEOUT: set `err`=1 and go to FIN.
  - FIN: `done`=1, `cmd`=ID, absorbing state.
- `din` is 0 in every state where `cmd`≠SP/SK.
- `ok` outside WAIT_OK is ignored.
- `ready` is sampled only in IDLE. Deassertion mid-load is ignored.

## Timing
- Reset values: `address`=0, `din`=0, `cmd`=ID, `vec_idx`=0, `done`=0, `err`=0, state IDLE, shift register 0, counters 0.
- Reset is asynchronous. Asserting `rst_` mid-transfer aborts immediately, with no partial byte completion. After release, the block restarts from vector 0.
- Per-vector load latency from leaving IDLE to `cmd`=ST: 2+16+1+2+16+1 = 38 cycles; ST is in cycle 39.
- WAIT_OK is entered the cycle after ST. `ok` in the same cycle the timeout counter hits OK_TIMEOUT counts as success: `ok` wins and `err` is not set.
- Timeout counter is width clog2(OK_TIMEOUT+1). It clears on entering WAIT_OK and does not wrap.
- `vec_idx` increments in the cycle after the accepting `ok`.
- `address` wraps never; ADDR_W constraint guarantees range.

## Structure
- Shared package `aes_pkg` holds:
  - CMD_ID/CMD_ST/CMD_SK/CMD_SP localparams.
  - The loader state enum typedef.
  - The 128-bit block typedef.
- One sub-module `aes_byte_shifter`:
  - 128-bit load/shift register with a 4-bit byte counter.
  - Inputs: load, shift. Outputs: byte[7:0], last.
- The FSM, the timeout counter and address generation stay in the top module.

## Test plan
- Reset sequence: hold `rst_`=0 for 10 cycles → all outputs at their reset values. After release with `ready`=0 → stays IDLE, `cmd`=ID.
- Single vector: word0=128'h00041214120412000c00131108231919, word1=128'h2475a2b33475568831e2120013aa5487, `ready`=1, then `ok` pulse 50 cycles after ST. Required response:
  - `address`=0, then 1.
  - `din` under SP is 19,19,23,08,…,00.
  - `din` under SK is 87,54,aa,13,…,24.
  - ST occurs in cycle 39.
  - `vec_idx` becomes 1.
- Full run, VEC_COUNT=20: cipher model returns `ok` after each ST → `done`=1 after exactly 20 `ok`s, `err`=0, and address reaches 39.
- Timeout: OK_TIMEOUT=16 and `ok` never asserted → `err`=1 and `done`=1 exactly 16 cycles after entering WAIT_OK, with `cmd` held at ID.
- Boundary conditions:
  - `ok` coincident with the timeout expiry → success, with `err`=0.
  - Spurious `ok` during SEND_PT → ignored; byte order is unchanged.
- Reset mid-SEND_KEY, at byte 7 → `cmd`=ID and `din`=0 immediately (asynchronous). After release, the block reloads vector 0 from address 0.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants and types for the AES vector loader
//
// Purpose : cipher command encodings, loader state enum, 128-bit block type.
// Ports   : none (package).

package aes_pkg;

    localparam logic [1:0] CMD_ID = 2'b00;
    localparam logic [1:0] CMD_ST = 2'b01;
    localparam logic [1:0] CMD_SK = 2'b10;
    localparam logic [1:0] CMD_SP = 2'b11;

    typedef logic [127:0] block_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_PT,
        S_SEND_PT,
        S_GAP_PT,
        S_RD_KEY,
        S_SEND_KEY,
        S_GAP_KEY,
        S_START,
        S_WAIT_OK,
        S_FIN
    } ldr_state_t;

endpackage

// File: rtl/aes_vector_loader_if.sv
// rtl/aes_vector_loader_if.sv - bundle between vector ROM, loader and cipher
//
// Purpose : groups the memory, cipher and status signals of the loader.
// Ports   : master = loader side (drives address/din/cmd/vec_idx/done/err,
//           samples rdata/ready/ok); slave = environment side (the reverse).

interface aes_vector_loader_if #(
    parameter int ADDR_W = 8
);
    import aes_pkg::*;

    logic [ADDR_W-1:0] address;
    block_t            rdata;
    logic [7:0]        din;
    logic [1:0]        cmd;
    logic              ready;
    logic              ok;
    logic [ADDR_W-2:0] vec_idx;
    logic              done;
    logic              err;

    modport master (
        output address, din, cmd, vec_idx, done, err,
        input  rdata, ready, ok
    );

    modport slave (
        input  address, din, cmd, vec_idx, done, err,
        output rdata, ready, ok
    );

endinterface

// File: rtl/aes_byte_shifter.sv
// rtl/aes_byte_shifter.sv - 128-bit load/shift register feeding bytes LSB first
//
// Purpose : holds one block and walks it out a byte at a time.
// Ports   : clk, rst_ (async active-low); i_load, i_data load a block;
//           i_shift drops the low byte; o_byte is the byte that sits at the
//           bottom after the coming edge; o_last flags the 16th byte.

module aes_byte_shifter
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_,
    input  logic       i_load,
    input  logic       i_shift,
    input  block_t     i_data,
    output logic [7:0] o_byte,
    output logic       o_last
);

    block_t     r_sreg;
    block_t     w_sreg_nxt;
    logic [3:0] r_cnt;

    always_comb begin
        w_sreg_nxt = r_sreg;
        if (i_load) begin
            w_sreg_nxt = i_data;
        end else if (i_shift) begin
            w_sreg_nxt = {8'h00, r_sreg[127:8]};
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else begin
            r_sreg <= w_sreg_nxt;
            if (i_load) begin
                r_cnt <= '0;
            end else if (i_shift) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Look-ahead byte lets the caller register din in step with the register.
    assign o_byte = w_sreg_nxt[7:0];
    assign o_last = (r_cnt == 4'd15);

endmodule

// File: rtl/aes_vector_loader.sv
// rtl/aes_vector_loader.sv - serializes plaintext/key vectors into aescipher
//
// Purpose : reads word 2n (plaintext) and 2n+1 (key), streams each as 16
//           bytes under SP/SK, issues ST, then waits for ok or a timeout.
// Ports   : clk, rst_ (async active-low); bus (master modport): address,
//           rdata, din, cmd, ready, ok, vec_idx, done, err.

module aes_vector_loader
    import aes_pkg::*;
#(
    parameter int VEC_COUNT  = 20,
    parameter int ADDR_W     = 8,
    parameter int OK_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst_,
    aes_vector_loader_if.master bus
);

    localparam int                TO_W     = $clog2(OK_TIMEOUT + 1);
    localparam logic [ADDR_W-2:0] LAST_IDX = (ADDR_W-1)'(VEC_COUNT - 1);

    ldr_state_t        r_state, w_state_nxt;
    logic              r_rd_phase;
    logic [TO_W-1:0]   r_to_cnt;
    logic [ADDR_W-1:0] r_address, w_address_nxt;
    logic [ADDR_W-2:0] r_vec_idx;
    logic [7:0]        r_din, w_din_nxt;
    logic [1:0]        r_cmd, w_cmd_nxt;
    logic              r_done, r_err;
    logic              w_load, w_shift, w_last, w_to_hit, w_vec_inc, w_set_err;
    logic [7:0]        w_byte;

    aes_byte_shifter u_shifter (
        .clk     (clk),
        .rst_    (rst_),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (bus.rdata),
        .o_byte  (w_byte),
        .o_last  (w_last)
    );

    // Last permitted WAIT_OK cycle; ok here still wins over the timeout.
    assign w_to_hit = (r_to_cnt == TO_W'(OK_TIMEOUT - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_address_nxt = r_address;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        w_vec_inc     = 1'b0;
        w_set_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ready && !r_done) begin
                    w_state_nxt   = S_RD_PT;
                    w_address_nxt = {r_vec_idx, 1'b0};
                end
            end
            S_RD_PT: begin
                if (r_rd_phase) begin
                    w_state_nxt = S_SEND_PT;
                    w_load      = 1'b1;
                end
            end
            S_SEND_PT: begin
                if (w_last) w_state_nxt = S_GAP_PT;
                else        w_shift     = 1'b1;
            end
            S_GAP_PT: begin
                w_state_nxt   = S_RD_KEY;
                w_address_nxt = {r_vec_idx, 1'b1};
            end
            S_RD_KEY: begin
                if (r_rd_phase) begin
                    w_state_nxt = S_SEND_KEY;
                    w_load      = 1'b1;
                end
            end
            S_SEND_KEY: begin
                if (w_last) w_state_nxt = S_GAP_KEY;
                else        w_shift     = 1'b1;
            end
            S_GAP_KEY: w_state_nxt = S_START;
            S_START:   w_state_nxt = S_WAIT_OK;
            S_WAIT_OK: begin
                if (bus.ok) begin
                    if (r_vec_idx == LAST_IDX) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_vec_inc   = 1'b1;
                    end
                end else if (w_to_hit) begin
                    w_state_nxt = S_FIN;
                    w_set_err   = 1'b1;
                end
            end
            S_FIN:   w_state_nxt = S_FIN;
            default: w_state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registers line up
        // with the state they describe.
        w_cmd_nxt = CMD_ID;
        w_din_nxt = 8'h00;
        case (w_state_nxt)
            S_SEND_PT: begin
                w_cmd_nxt = CMD_SP;
                w_din_nxt = w_byte;
            end
            S_SEND_KEY: begin
                w_cmd_nxt = CMD_SK;
                w_din_nxt = w_byte;
            end
            S_START: w_cmd_nxt = CMD_ST;
            default: w_cmd_nxt = CMD_ID;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state    <= S_IDLE;
            r_rd_phase <= 1'b0;
            r_to_cnt   <= '0;
            r_address  <= '0;
            r_vec_idx  <= '0;
            r_din      <= '0;
            r_cmd      <= CMD_ID;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_address <= w_address_nxt;
            r_din     <= w_din_nxt;
            r_cmd     <= w_cmd_nxt;
            // Second read cycle marker: memory data is valid one cycle late.
            r_rd_phase <= (r_state == S_RD_PT || r_state == S_RD_KEY) ? ~r_rd_phase : 1'b0;
            if (r_state != S_WAIT_OK && w_state_nxt == S_WAIT_OK) begin
                r_to_cnt <= '0;
            end else if (r_state == S_WAIT_OK && r_to_cnt != TO_W'(OK_TIMEOUT)) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_vec_inc)              r_vec_idx <= r_vec_idx + 1'b1;
            if (w_state_nxt == S_FIN)   r_done    <= 1'b1;
            if (w_set_err)              r_err     <= 1'b1;
        end
    end

    assign bus.address = r_address;
    assign bus.din     = r_din;
    assign bus.cmd     = r_cmd;
    assign bus.vec_idx = r_vec_idx;
    assign bus.done    = r_done;
    assign bus.err     = r_err;

endmodule

// File: tb/tb_aes_vector_loader.sv
// tb/tb_aes_vector_loader.sv - scoreboard bench for aes_vector_loader

module tb_aes_vector_loader;
    import aes_pkg::*;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] din;
        logic [7:0] addr;
    } ev_t;

    logic   clk;
    logic   rst_a_n, rst_b_n;
    int     cyc, ref_cyc, n_checks, n_pass;
    int     sk_cnt, st_cnt, ok_vec;
    bit     mute;
    ev_t    exp_q[$];
    block_t mem_a [0:255];

    aes_vector_loader_if #(.ADDR_W(8)) bus_a ();
    aes_vector_loader_if #(.ADDR_W(2)) bus_b ();

    aes_vector_loader #(.VEC_COUNT(20), .ADDR_W(8), .OK_TIMEOUT(4096)) u_dut (
        .clk  (clk),
        .rst_ (rst_a_n),
        .bus  (bus_a.master)
    );

    aes_vector_loader #(.VEC_COUNT(2), .ADDR_W(2), .OK_TIMEOUT(16)) u_dut_to (
        .clk  (clk),
        .rst_ (rst_b_n),
        .bus  (bus_b.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: each vector is 16 plaintext bytes LSB first, 16 key bytes, then ST.
    task automatic push_vector(input int n, input int n_key);
        block_t pt, key;
        pt  = mem_a[2*n];
        key = mem_a[2*n+1];
        for (int b = 0; b < 16; b++)
            exp_q.push_back('{cmd: CMD_SP, din: 8'(pt >> (8*b)), addr: 8'(2*n)});
        for (int b = 0; b < n_key; b++)
            exp_q.push_back('{cmd: CMD_SK, din: 8'(key >> (8*b)), addr: 8'(2*n+1)});
        if (n_key == 16)
            exp_q.push_back('{cmd: CMD_ST, din: 8'h00, addr: 8'(2*n+1)});
    endtask

    // Synchronous vector memory: address seen in one cycle, data in the next.
    initial begin
        logic [7:0] a;
        forever begin
            @(negedge clk);
            a = bus_a.address;
            @(posedge clk);
            #1;
            bus_a.rdata = mem_a[a];
        end
    end

    // Monitor: pops one expected event per non-idle cycle.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (bus_a.cmd != CMD_ID) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: cmd %0d din %0h, required no output", bus_a.cmd, bus_a.din);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd", bus_a.cmd, e.cmd);
                    check("din", bus_a.din, e.din);
                    check("address", bus_a.address, e.addr);
                    if (bus_a.cmd == CMD_SK) sk_cnt++;
                    if (bus_a.cmd == CMD_ST) begin
                        st_cnt++;
                        check("st_cycle", cyc - ref_cyc, 39);
                    end
                end
            end else begin
                check("din_idle", bus_a.din, 0);
            end
        end
    end

    // Cipher model: ok some cycles after ST, stray ok pulses during SP.
    initial begin
        int wait_cnt;
        bit chk_next;
        wait_cnt = 0;
        chk_next = 0;
        forever begin
            @(posedge clk);
            #1;
            if (chk_next) begin
                chk_next = 0;
                if (ok_vec < 20) check("vec_idx", bus_a.vec_idx, ok_vec);
                else begin
                    check("done_after_last_ok", bus_a.done, 1);
                    check("err_after_last_ok", bus_a.err, 0);
                end
            end
            bus_a.ok = 1'b0;
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    bus_a.ok = 1'b1;
                    ok_vec++;
                    ref_cyc  = cyc + 1;
                    chk_next = 1;
                end
            end else if (bus_a.cmd == CMD_ST && !mute) begin
                wait_cnt = (ok_vec == 0) ? 50 : int'($urandom_range(1, 30));
            end else if (bus_a.cmd == CMD_SP && $urandom_range(0, 5) == 0) begin
                bus_a.ok = 1'b1;
            end
        end
    end

    initial begin
        int k, c;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        mute = 0;
        bus_a.ready = 1'b0;
        bus_a.ok    = 1'b0;
        bus_a.rdata = '0;
        bus_b.ready = 1'b0;
        bus_b.ok    = 1'b0;
        bus_b.rdata = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 256; i++) mem_a[i] = (i < 40) ? {$urandom, $urandom, $urandom, $urandom} : '0;
        mem_a[0] = 128'h00041214120412000c00131108231919;
        mem_a[1] = 128'h2475a2b33475568831e2120013aa5487;

        repeat (10) @(posedge clk);
        #1;
        check("rst_address", bus_a.address, 0);
        check("rst_din", bus_a.din, 0);
        check("rst_cmd", bus_a.cmd, CMD_ID);
        check("rst_vec_idx", bus_a.vec_idx, 0);
        check("rst_done", bus_a.done, 0);
        check("rst_err", bus_a.err, 0);
        rst_a_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_no_ready_cmd", bus_a.cmd, CMD_ID);
        check("idle_no_ready_addr", bus_a.address, 0);

        // Full 20-vector run; vector 0 uses the reference words.
        for (int n = 0; n < 20; n++) push_vector(n, 16);
        @(posedge clk);
        #1;
        bus_a.ready = 1'b1;
        ref_cyc = cyc;
        k = 0;
        while (!bus_a.done && k < 4000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("run_done", bus_a.done, 1);
        check("ok_count", ok_vec, 20);
        check("run_err", bus_a.err, 0);
        check("final_address", bus_a.address, 39);
        check("queue_drained", exp_q.size(), 0);

        // Restart from vector 0, then reset asynchronously at key byte 7.
        mute = 1;
        sk_cnt = 0;
        st_cnt = 0;
        push_vector(0, 8);
        @(posedge clk);
        #1;
        rst_a_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_a_n = 1'b1;
        ref_cyc = cyc;
        k = 0;
        while (sk_cnt < 8 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("reached_key_byte7", sk_cnt, 8);
        rst_a_n = 1'b0;
        #1;
        check("async_rst_cmd", bus_a.cmd, CMD_ID);
        check("async_rst_din", bus_a.din, 0);
        check("async_rst_addr", bus_a.address, 0);
        check("partial_queue_drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        push_vector(0, 16);
        rst_a_n = 1'b1;
        ref_cyc = cyc;
        k = 0;
        while (st_cnt < 1 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("reload_st_seen", st_cnt, 1);
        check("reload_queue_drained", exp_q.size(), 0);

        // Timeout block: ok on the expiry cycle wins, then no ok at all.
        @(posedge clk);
        #1;
        rst_b_n = 1'b1;
        bus_b.ready = 1'b1;
        c = cyc;
        k = 0;
        while (bus_b.cmd != CMD_ST && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("b_st_cycle", cyc - c, 39);
        c = cyc;
        repeat (16) @(posedge clk);
        #1;
        check("b_err_before_expiry", bus_b.err, 0);
        bus_b.ok = 1'b1;
        @(posedge clk);
        #1;
        bus_b.ok = 1'b0;
        check("b_coincident_ok_err", bus_b.err, 0);
        check("b_coincident_ok_done", bus_b.done, 0);
        check("b_vec_idx", bus_b.vec_idx, 1);
        k = 0;
        while (bus_b.cmd != CMD_ST && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("b_second_st", bus_b.cmd, CMD_ST);
        repeat (16) @(posedge clk);
        #1;
        check("b_err_at_16", bus_b.err, 0);
        check("b_done_at_16", bus_b.done, 0);
        check("b_cmd_wait", bus_b.cmd, CMD_ID);
        @(posedge clk);
        #1;
        check("b_err_at_17", bus_b.err, 1);
        check("b_done_at_17", bus_b.done, 1);
        check("b_cmd_fin", bus_b.cmd, CMD_ID);
        repeat (3) @(posedge clk);
        #1;
        check("b_err_sticky", bus_b.err, 1);
        check("b_done_sticky", bus_b.done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
